// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback formatter.
// Drives the register-file write port, a forwarding copy and a retire counter.
module writeback_stage #(
    parameter int DATA_W   = 32,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic                in_reg_write,
    input  logic                in_mem_to_reg,
    input  logic [4:0]          in_wb_addr,
    input  logic [DATA_W-1:0]   in_alu_result,
    input  logic [DATA_W-1:0]   in_load_data,
    input  logic [1:0]          in_load_size,
    input  logic                in_load_signed,
    input  logic                stall,
    input  logic                flush,
    output logic                reg_write_en,
    output logic [4:0]          write_addr,
    output logic [DATA_W-1:0]   write_data,
    output logic                fwd_valid,
    output logic                misalign_err,
    output logic [RETIRE_W-1:0] retire_count
);

    logic                valid_q, valid_d;
    logic                rw_q, rw_d;
    logic [4:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                mis_q, mis_d;
    logic [RETIRE_W-1:0] cnt_q, cnt_d;

    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic        misaligned;
    logic        take;
    logic        mis_cap;

    always_comb begin
        off     = in_alu_result[1:0];
        ld_byte = 8'h00;
        unique case (off)
            2'd0: ld_byte = in_load_data[7:0];
            2'd1: ld_byte = in_load_data[15:8];
            2'd2: ld_byte = in_load_data[23:16];
            2'd3: ld_byte = in_load_data[31:24];
        endcase
        ld_half = off[1] ? in_load_data[31:16] : in_load_data[15:0];
        unique case (in_load_size)
            2'b00:   ld_fmt = {{24{in_load_signed & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{in_load_signed & ld_half[15]}}, ld_half};
            default: ld_fmt = in_load_data;
        endcase
        misaligned = (in_load_size == 2'b11)
                   | ((in_load_size == 2'b01) & off[0])
                   | ((in_load_size == 2'b10) & (off != 2'b00));
    end

    assign take    = in_valid & ~flush;
    assign mis_cap = take & in_mem_to_reg & misaligned;

    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;
        if (!stall) begin
            valid_d = take;
            // A misaligned load retires but must never reach the register file
            rw_d    = in_reg_write & ~mis_cap;
            addr_d  = in_wb_addr;
            data_d  = in_mem_to_reg ? ld_fmt : in_alu_result;
            mis_d   = mis_cap;
            if (take) begin
                cnt_d = cnt_q + RETIRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= 5'd0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_valid    = valid_q & rw_q & (addr_q != 5'd0);
    assign reg_write_en = fwd_valid & ~stall;
    assign write_addr   = addr_q;
    assign write_data   = data_q;
    assign misalign_err = mis_q;
    assign retire_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed spec cases then random
// traffic, compared against a behavioural model of the stage.
module tb_writeback_stage;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_reg_write, in_mem_to_reg;
    logic [4:0]    in_wb_addr;
    logic [31:0]   in_alu_result, in_load_data;
    logic [1:0]    in_load_size;
    logic          in_load_signed, stall, flush;
    logic          reg_write_en;
    logic [4:0]    write_addr;
    logic [31:0]   write_data;
    logic          fwd_valid, misalign_err;
    logic [RW-1:0] retire_count;

    int n_chk = 0;
    int n_err = 0;

    // model state
    bit          m_valid, m_rw, m_mis;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    int unsigned m_cnt;

    writeback_stage #(.DATA_W(32), .RETIRE_W(RW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_wb_addr(in_wb_addr),
        .in_alu_result(in_alu_result), .in_load_data(in_load_data),
        .in_load_size(in_load_size), .in_load_signed(in_load_signed),
        .stall(stall), .flush(flush),
        .reg_write_en(reg_write_en), .write_addr(write_addr),
        .write_data(write_data), .fwd_valid(fwd_valid),
        .misalign_err(misalign_err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] fmt(bit [31:0] d, int off, int size, bit sgn);
        int unsigned b, h;
        case (size)
            0: begin
                b = (d >> (8 * off)) % 256;
                return (sgn && b >= 128) ? b + 32'hFFFF_FF00 : b;
            end
            1: begin
                h = (d >> (16 * (off / 2))) % 65536;
                return (sgn && h >= 32768) ? h + 32'hFFFF_0000 : h;
            end
            default: return d;
        endcase
    endfunction

    function automatic bit is_mis(int off, int size);
        return size == 3 || (size == 1 && off % 2 == 1) || (size == 2 && off != 0);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mis = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int  off;
        bit  mis;
        off = int'(in_alu_result % 4);
        if (stall) begin
            m_mis = 0;
        end else begin
            mis     = in_valid && !flush && in_mem_to_reg && is_mis(off, int'(in_load_size));
            m_valid = in_valid && !flush;
            m_rw    = in_reg_write && !mis;
            m_addr  = in_wb_addr;
            m_data  = in_mem_to_reg ?
                      fmt(in_load_data, off, int'(in_load_size), in_load_signed) :
                      in_alu_result;
            m_mis   = mis;
            if (m_valid) m_cnt = (m_cnt + 1) % (1 << RW);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        bit fv;
        fv = m_valid && m_rw && (m_addr != 0);
        chk({tag, ".we"},   32'(reg_write_en), 32'(fv && !stall));
        chk({tag, ".fwd"},  32'(fwd_valid),    32'(fv));
        chk({tag, ".addr"}, 32'(write_addr),   32'(m_addr));
        chk({tag, ".data"}, write_data,        m_data);
        chk({tag, ".mis"},  32'(misalign_err), 32'(m_mis));
        chk({tag, ".cnt"},  32'(retire_count), m_cnt);
    endtask

    task automatic drv(bit v, bit rw, bit m2r, bit [4:0] a, bit [31:0] alu,
                       bit [31:0] ld, bit [1:0] sz, bit sg, bit st, bit fl);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_wb_addr = a;
        in_alu_result = alu; in_load_data = ld; in_load_size = sz;
        in_load_signed = sg; stall = st; flush = fl;
    endtask

    task automatic idle(bit st);
        drv(0, 0, 0, 5'd0, 32'h0, 32'h0, 2'b00, 0, st, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
    endtask

    task automatic step(string tag);
        #1 check_model(tag);
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        idle(0);
        model_reset();
        #1 check_model("reset");
        chk("reset.cnt0", 32'(retire_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU op
        drv(1, 1, 0, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 2'b10, 0, 0, 0);
        step("alu.in");
        idle(0);
        #1 check_model("alu.out");
        chk("alu.we", 32'(reg_write_en), 32'd1);
        chk("alu.addr", 32'(write_addr), 32'd5);
        chk("alu.data", write_data, 32'h0000_1234);

        // signed / unsigned byte at off 3
        tick();
        drv(1, 1, 1, 5'd7, 32'h0000_0003, 32'h80FF_7F01, 2'b00, 1, 0, 0);
        step("sb.in");
        drv(1, 1, 1, 5'd8, 32'h0000_0003, 32'h80FF_7F01, 2'b00, 0, 0, 0);
        #1 check_model("sb.out");
        chk("sb.data", write_data, 32'hFFFF_FF80);
        tick();
        idle(0);
        #1 check_model("ub.out");
        chk("ub.data", write_data, 32'h0000_0080);
        tick();

        // half at off 2, then misaligned half at off 1
        drv(1, 1, 1, 5'd9, 32'h0000_0002, 32'h8001_0000, 2'b01, 1, 0, 0);
        step("sh.in");
        drv(1, 1, 1, 5'd10, 32'h0000_0001, 32'h8001_0000, 2'b01, 1, 0, 0);
        #1 check_model("sh.out");
        chk("sh.data", write_data, 32'hFFFF_8001);
        tick();
        idle(0);
        #1 check_model("mis.out");
        chk("mis.err", 32'(misalign_err), 32'd1);
        chk("mis.we", 32'(reg_write_en), 32'd0);
        tick();
        #1 check_model("mis.after");
        chk("mis.pulse", 32'(misalign_err), 32'd0);

        // write to r0
        drv(1, 1, 0, 5'd0, 32'h1111_2222, 32'h0, 2'b00, 0, 0, 0);
        step("r0.in");
        idle(0);
        #1 check_model("r0.out");
        chk("r0.we", 32'(reg_write_en), 32'd0);
        chk("r0.fwd", 32'(fwd_valid), 32'd0);
        tick();

        // stall 3 cycles after capture: exactly one strobe after release
        drv(1, 1, 0, 5'd12, 32'hCAFE_0001, 32'h0, 2'b00, 0, 0, 0);
        step("st.in");
        for (int i = 0; i < 3; i++) begin
            idle(1);
            #1 check_model("st.hold");
            chk("st.we_off", 32'(reg_write_en), 32'd0);
            chk("st.fwd_on", 32'(fwd_valid), 32'd1);
            tick();
        end
        idle(0);
        #1 check_model("st.rel");
        chk("st.we_on", 32'(reg_write_en), 32'd1);
        tick();
        #1 check_model("st.once");
        chk("st.we_once", 32'(reg_write_en), 32'd0);

        // flush with valid: bubble
        drv(1, 1, 0, 5'd13, 32'h0BAD_0BAD, 32'h0, 2'b00, 0, 0, 1);
        step("fl.in");
        idle(0);
        #1 check_model("fl.out");
        chk("fl.we", 32'(reg_write_en), 32'd0);
        tick();

        // reset asserted mid-stall
        drv(1, 1, 1, 5'd14, 32'h0000_0002, 32'h1234_5678, 2'b01, 1, 0, 0);
        step("rs.in");
        idle(1);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_model("rs.mid");
        chk("rs.we", 32'(reg_write_en), 32'd0);
        chk("rs.fwd", 32'(fwd_valid), 32'd0);
        chk("rs.data", write_data, 32'd0);
        chk("rs.cnt", 32'(retire_count), 32'd0);
        #1 reset_n = 1'b1;
        idle(0);
        tick();

        // 17 retires on a 4-bit counter wrap to 1
        for (int i = 0; i < 17; i++) begin
            drv(1, i[0], i[1], 5'(i), 32'(i), 32'h0, 2'(i), 0, 0, 0);
            step("cnt.in");
        end
        idle(0);
        #1 check_model("cnt.out");
        chk("cnt.wrap", 32'(retire_count), 32'd1);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                $urandom, $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 6) == 0);
            step("rnd");
        end
        idle(0);
        #1 check_model("end");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
